// File: rtl/mul_pkg.sv
// Shared definitions for the signed Wallace-tree multiplier.
// Covers the operand and product widths, the radix-4 Booth digit encoding,
// and the helpers that size the carry-save reduction tree.
package mul_pkg;

  localparam int WIDTH  = 32;
  localparam int PROD_W = 2 * WIDTH;

  // Radix-4 Booth digit selected by one overlapping multiplier triplet.
  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_M1   = 3'd2,
    BOOTH_P2   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_e;

  // Triplet {b[2i+1], b[2i], b[2i-1]} -> digit in {-2, -1, 0, +1, +2}.
  function automatic booth_e booth_decode(input logic [2:0] trip);
    booth_e dig;
    case (trip)
      3'b001, 3'b010: dig = BOOTH_P1;
      3'b011:         dig = BOOTH_P2;
      3'b100:         dig = BOOTH_M2;
      3'b101, 3'b110: dig = BOOTH_M1;
      default:        dig = BOOTH_ZERO;
    endcase
    return dig;
  endfunction

  // Vector count after one level of 3:2 compression.
  // Each full group of three becomes two; leftovers pass straight through.
  function automatic int csa_next(input int n);
    return (n / 3) * 2 + (n % 3);
  endfunction

  // Vector count entering tree level lvl, starting from n partial products.
  function automatic int csa_count(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = csa_next(c);
    return c;
  endfunction

  // Number of compression levels needed to get from n vectors down to two.
  function automatic int csa_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (c > 2) begin
        c = csa_next(c);
        l++;
      end
    end
    return l;
  endfunction

  // Start index of tree level lvl inside the flat vector array.
  // All levels are stored back to back in that array.
  function automatic int csa_offset(input int n, input int lvl);
    int off;
    off = 0;
    for (int i = 0; i < lvl; i++) off += csa_count(n, i);
    return off;
  endfunction

endpackage

// File: rtl/wallace_csa.sv
// Bit-vector 3:2 compressor used at every level of the Wallace tree.
// The carry vector is already shifted into its weight, and the top
// majority bit is dropped because the product width bounds the tree.
module wallace_csa #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // Sum is the bitwise parity and carry is the majority one place up.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
  end

endmodule

// File: rtl/wallace_mul32.sv
// Signed WIDTH x WIDTH -> 2*WIDTH multiplier.
// Radix-4 Booth partial products feed a Wallace tree of 3:2 compressors,
// a single carry-propagate add resolves the tree, and the product register
// gives one cycle of latency.
module wallace_mul32
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int PW   = 2 * WIDTH;
  // One vector per Booth digit, plus one vector that carries the +1
  // corrections for the negated digits.
  localparam int NPP  = WIDTH / 2 + 1;
  localparam int NLVL = csa_levels(NPP);
  localparam int NVEC = csa_offset(NPP, NLVL) + 2;

  logic [PW-1:0] pp [NPP];
  logic [PW-1:0] vec [NVEC];
  logic [PW-1:0] sum_final;
  logic [PW-1:0] product_d, product_q;
  logic          out_valid_d, out_valid_q;

  // Booth partial products.
  // A negative digit uses the inverted magnitude, and its +1 lands in
  // the last vector at bit 2i, so no adder is needed at this stage.
  always_comb begin
    logic [PW-1:0] a_ext;
    logic [PW-1:0] mag;
    logic [WIDTH:0] b_ext;
    booth_e         dig;
    a_ext = {{WIDTH{A[WIDTH-1]}}, A};
    b_ext = {B, 1'b0};
    mag   = '0;
    dig   = BOOTH_ZERO;
    for (int i = 0; i < NPP; i++) pp[i] = '0;
    for (int i = 0; i < NPP - 1; i++) begin
      dig = booth_decode(b_ext[2*i +: 3]);
      case (dig)
        BOOTH_P1, BOOTH_M1: mag = a_ext;
        BOOTH_P2, BOOTH_M2: mag = a_ext << 1;
        default:            mag = '0;
      endcase
      if (dig == BOOTH_M1 || dig == BOOTH_M2) begin
        pp[i]            = (~mag) << (2 * i);
        pp[NPP-1][2*i]   = 1'b1;
      end else begin
        pp[i]            = mag << (2 * i);
      end
    end
  end

  // Level 0 of the tree is the partial-product set itself.
  for (genvar j = 0; j < NPP; j++) begin : g_l0
    assign vec[j] = pp[j];
  end

  // Wallace reduction.
  // Each level compresses full groups of three and forwards any
  // leftover vectors unchanged to the next level.
  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int N       = csa_count(NPP, l);
    localparam int IN_OFF  = csa_offset(NPP, l);
    localparam int OUT_OFF = csa_offset(NPP, l + 1);
    localparam int NG      = N / 3;
    for (genvar g = 0; g < NG; g++) begin : g_csa
      wallace_csa #(.W(PW)) u_csa (
        .a     (vec[IN_OFF + 3*g]),
        .b     (vec[IN_OFF + 3*g + 1]),
        .c     (vec[IN_OFF + 3*g + 2]),
        .sum   (vec[OUT_OFF + 2*g]),
        .carry (vec[OUT_OFF + 2*g + 1])
      );
    end
    for (genvar r = 0; r < N - 3*NG; r++) begin : g_pass
      assign vec[OUT_OFF + 2*NG + r] = vec[IN_OFF + 3*NG + r];
    end
  end

  // Final carry-propagate add of the last sum/carry pair.
  assign sum_final = vec[NVEC-2] + vec[NVEC-1];

  // Next-state logic: capture on in_valid, otherwise hold the product.
  // Holding means X on the idle operands never reaches the register.
  always_comb begin
    out_valid_d = in_valid;
    product_d   = in_valid ? sum_final : product_q;
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Product   = product_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wallace_mul32.sv
// Scoreboard bench for wallace_mul32.
// The driver queues the expected product whenever it issues a multiply.
// The monitor pops and compares on every out_valid, and checks that
// Product holds its last value on idle cycles.
module tb_wallace_mul32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic [63:0] Product;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_prod = '0;

  always #5 clk = ~clk;

  wallace_mul32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Product   (Product)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain signed 64-bit multiply of the sign-extended operands.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
    @(negedge clk);
    in_valid = 1'b1;
    A = a;
    B = b;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    logic [63:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", {63'd0, out_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("product", Product, e);
          model_prod = e;
        end
      end else begin
        check("hold", Product, model_prod);
        if (exp_q.size() != 0) begin
          check("missing_valid", {63'd0, out_valid}, 64'd1);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] pool [6];
    pool[0] = 32'h8000_0000;
    pool[1] = 32'h7FFF_FFFF;
    pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h0000_0000;
    pool[4] = 32'h0000_0001;
    pool[5] = 32'hAAAA_AAAA;

    #1;
    check("rst_product", Product, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sign mixes.
    issue(32'sd20,   -32'sd3,   64'hFFFF_FFFF_FFFF_FFC4);
    issue(32'sd77,   32'sd88,   64'sd6776);
    issue(-32'sd90,  -32'sd90,  64'sd8100);
    issue(-32'sd100, 32'sd99,   -64'sd9900);
    // Identities.
    issue(32'sd0,    32'sd98765, 64'sd0);
    issue(32'sd1,    32'sd98765, 64'sd98765);
    issue(-32'sd200, 32'sd4008,  -64'sd801600);
    issue(-32'sd111, -32'sd2222, 64'sd246642);
    // Extremes.
    issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

    // Valid gating: the product must hold while idle operands change.
    issue(32'sd123, 32'sd456, 64'sd56088);
    idle();
    idle();
    @(negedge clk);
    in_valid = 1'b0;
    A = 'x;
    B = 'x;
    idle();

    // Reset mid-stream: the in-flight result is discarded.
    issue(32'sd7, 32'sd9, 64'sd63);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_product", Product, 64'd0);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    exp_q.delete();
    model_prod = '0;
    @(negedge clk);
    in_valid = 1'b1;
    A = 32'd5;
    B = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    issue(-32'sd5, 32'sd6, -64'sd30);

    // Random back-to-back operations, with some drawn from a corner pool.
    for (int i = 0; i < 10000; i++) begin
      ra = ($urandom_range(7) == 0) ? pool[$urandom_range(5)] : $urandom;
      rb = ($urandom_range(7) == 0) ? pool[$urandom_range(5)] : $urandom;
      issue(ra, rb, ref_mul(ra, rb));
    end

    idle();
    idle();
    idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
